// File: rtl/cve2_mac_accum_unit.sv
// cve2_mac_accum_unit: multiply-accumulate writeback stage behind the MAC controller.
// Adds the multiplier low word to the latched rd operand and hands the result over valid/ready.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   start_i             MAC accepted; acc_operand_i is sampled with it
//   acc_operand_i       accumulator operand (old rd value)
//   mul_valid_i         multiplier low-word product valid
//   mul_result_i        multiplier low-word product
//   kill_i              synchronous flush, highest priority
//   result_ready_i      writeback accepts result
//   result_valid_o      result_o / ovf_o valid
//   result_o            accumulated (optionally saturated) result
//   ovf_o               signed overflow flag for result_o
//   busy_o              unit is not idle

module cve2_mac_accum_unit #(
    parameter int unsigned Width    = 32,
    parameter bit          Saturate = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [Width-1:0] acc_operand_i,
    input  logic             mul_valid_i,
    input  logic [Width-1:0] mul_result_i,
    input  logic             kill_i,
    input  logic             result_ready_i,
    output logic             result_valid_o,
    output logic [Width-1:0] result_o,
    output logic             ovf_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_MUL = 2'b01,
        ADD      = 2'b10,
        HOLD     = 2'b11
    } state_e;

    localparam logic [Width-1:0] MaxPos = {1'b0, {(Width-1){1'b1}}};
    localparam logic [Width-1:0] MinNeg = {1'b1, {(Width-1){1'b0}}};

    state_e state_q;
    state_e state_d;

    logic [Width-1:0] acc_q;
    logic [Width-1:0] prod_q;
    logic [Width-1:0] result_q;
    logic [Width-1:0] result_d;
    logic             ovf_q;
    logic             ovf_d;

    logic acc_we;
    logic prod_we;
    logic res_we;

    logic [Width:0] sum;
    logic           sum_ovf;

    // Next-state and register write enables
    always_comb begin
        state_d = state_q;
        acc_we  = 1'b0;
        prod_we = 1'b0;
        res_we  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    acc_we  = 1'b1;
                    state_d = WAIT_MUL;
                end
            end
            WAIT_MUL: begin
                if (mul_valid_i) begin
                    prod_we = 1'b1;
                    state_d = ADD;
                end
            end
            ADD: begin
                res_we  = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (result_ready_i) begin
                    if (start_i) begin
                        // back-to-back: next operand taken in the handshake cycle
                        acc_we  = 1'b1;
                        state_d = WAIT_MUL;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A flush wins over everything, including a back-to-back start
        if (kill_i) begin
            state_d = IDLE;
            acc_we  = 1'b0;
            prod_we = 1'b0;
            res_we  = 1'b0;
        end
    end

    // Sign-extended add; the extra bit exposes signed overflow
    always_comb begin
        sum     = {prod_q[Width-1], prod_q} + {acc_q[Width-1], acc_q};
        sum_ovf = sum[Width] ^ sum[Width-1];
        ovf_d   = sum_ovf;
        if (Saturate && sum_ovf) begin
            result_d = sum[Width] ? MinNeg : MaxPos;
        end else begin
            result_d = sum[Width-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else if (acc_we) begin
            acc_q <= acc_operand_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prod_q <= '0;
        end else if (prod_we) begin
            prod_q <= mul_result_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else if (res_we) begin
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result_valid_o = (state_q == HOLD);
    assign busy_o         = (state_q != IDLE);
    assign result_o       = result_q;
    assign ovf_o          = ovf_q;

endmodule

// File: tb/tb_cve2_mac_accum_unit.sv
// tb_cve2_mac_accum_unit: wrap and saturating instances driven in parallel,
// checked each cycle against a transaction-level model plus literal expectations.

module tb_cve2_mac_accum_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] acc_op;
    logic        mul_valid;
    logic [31:0] mul_res;
    logic        kill;
    logic        ready;

    logic        v0, v1;
    logic [31:0] r0, r1;
    logic        o0, o1;
    logic        b0, b1;

    int n_cmp = 0;
    int n_bad = 0;

    cve2_mac_accum_unit #(.Width(32), .Saturate(1'b0)) u_wrap (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .acc_operand_i  (acc_op),
        .mul_valid_i    (mul_valid),
        .mul_result_i   (mul_res),
        .kill_i         (kill),
        .result_ready_i (ready),
        .result_valid_o (v0),
        .result_o       (r0),
        .ovf_o          (o0),
        .busy_o         (b0)
    );

    cve2_mac_accum_unit #(.Width(32), .Saturate(1'b1)) u_sat (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .acc_operand_i  (acc_op),
        .mul_valid_i    (mul_valid),
        .mul_result_i   (mul_res),
        .kill_i         (kill),
        .result_ready_i (ready),
        .result_valid_o (v1),
        .result_o       (r1),
        .ovf_o          (o1),
        .busy_o         (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- transaction-level model ----
    // pending: operand taken, product awaited
    // have_prod: product taken, result appears one cycle later
    // out_valid: result offered to writeback
    bit          m_pending, m_have_prod, m_out_valid;
    logic [31:0] m_acc, m_prod;
    logic [31:0] m_res_wrap, m_res_sat;
    bit          m_ovf;

    function automatic logic [32:0] mac(input logic [31:0] a, input logic [31:0] p, input bit sat);
        longint s;
        bit     ov;
        logic [31:0] r;
        s  = longint'($signed(a)) + longint'($signed(p));
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        r  = s[31:0];
        if (sat && ov) r = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        return {ov, r};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [32:0] w, s;
        if (!rst_n) begin
            m_pending   <= 0;
            m_have_prod <= 0;
            m_out_valid <= 0;
            m_acc       <= '0;
            m_prod      <= '0;
        end else if (kill) begin
            m_pending   <= 0;
            m_have_prod <= 0;
            m_out_valid <= 0;
        end else if (m_out_valid) begin
            if (ready) begin
                m_out_valid <= 0;
                if (start) begin
                    m_pending <= 1;
                    m_acc     <= acc_op;
                end
            end
        end else if (m_have_prod) begin
            w = mac(m_acc, m_prod, 1'b0);
            s = mac(m_acc, m_prod, 1'b1);
            m_res_wrap  <= w[31:0];
            m_res_sat   <= s[31:0];
            m_ovf       <= w[32];
            m_have_prod <= 0;
            m_out_valid <= 1;
        end else if (m_pending) begin
            if (mul_valid) begin
                m_prod      <= mul_res;
                m_pending   <= 0;
                m_have_prod <= 1;
            end
        end else if (start) begin
            m_pending <= 1;
            m_acc     <= acc_op;
        end
    end

    // ---- per-cycle compare ----
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        bit busy;
        busy = m_pending || m_have_prod || m_out_valid;
        cmp("wrap.valid", 32'(v0), 32'(m_out_valid));
        cmp("sat.valid", 32'(v1), 32'(m_out_valid));
        cmp("wrap.busy", 32'(b0), 32'(busy));
        cmp("sat.busy", 32'(b1), 32'(busy));
        if (m_out_valid) begin
            cmp("wrap.result", r0, m_res_wrap);
            cmp("sat.result", r1, m_res_sat);
            cmp("wrap.ovf", 32'(o0), 32'(m_ovf));
            cmp("sat.ovf", 32'(o1), 32'(m_ovf));
        end
    end

    // ---- stimulus helpers ----
    task automatic idle_inputs();
        start     = 0;
        mul_valid = 0;
        kill      = 0;
        ready     = 0;
        acc_op    = '0;
        mul_res   = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!v0 && n < 20) begin
            tick();
            n++;
        end
        if (!v0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: result_valid_o never rose (got 0 expected 1)", name);
        end
    endtask

    // start, product on the next cycle, ends with result held (ready low)
    task automatic mac_to_hold(input logic [31:0] a, input logic [31:0] p);
        start  = 1;
        acc_op = a;
        tick();
        start     = 0;
        mul_valid = 1;
        mul_res   = p;
        tick();
        mul_valid = 0;
        tick();
    endtask

    task automatic consume();
        ready = 1;
        tick();
        ready = 0;
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] c [5];
        c[0] = 32'h0;
        c[1] = 32'h1;
        c[2] = 32'h7FFF_FFFF;
        c[3] = 32'h8000_0000;
        c[4] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        idle_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        cmp("reset.valid", 32'(v0), 32'h0);
        cmp("reset.busy", 32'(b0), 32'h0);
        cmp("reset.result", r0, 32'h0);
        cmp("reset.ovf", 32'(o0), 32'h0);
        rst_n = 1;
        tick();

        // basic: 5 + 6, valid exactly two cycles after mul_valid
        start  = 1;
        acc_op = 32'd5;
        tick();
        start     = 0;
        mul_valid = 1;
        mul_res   = 32'd6;
        tick();
        mul_valid = 0;
        cmp("basic.valid_early", 32'(v0), 32'h0);
        tick();
        cmp("basic.valid", 32'(v0), 32'h1);
        cmp("basic.result", r0, 32'd11);
        cmp("basic.ovf", 32'(o0), 32'h0);
        consume();
        cmp("basic.idle", 32'(b0), 32'h0);

        // multiplier stall and writeback backpressure
        start  = 1;
        acc_op = 32'h8;
        tick();
        start = 0;
        repeat (4) begin
            cmp("stall.busy", 32'(b0), 32'h1);
            tick();
        end
        mul_valid = 1;
        mul_res   = 32'h8;
        tick();
        mul_valid = 0;
        tick();
        repeat (3) begin
            cmp("bp.result", r0, 32'h10);
            cmp("bp.busy", 32'(b0), 32'h1);
            tick();
        end
        consume();
        cmp("bp.idle", 32'(b0), 32'h0);

        // overflow, wrap vs saturate
        mac_to_hold(32'h7FFF_FFFF, 32'h1);
        cmp("ovf.wrap", r0, 32'h8000_0000);
        cmp("ovf.sat", r1, 32'h7FFF_FFFF);
        cmp("ovf.flag", 32'(o1), 32'h1);
        consume();
        mac_to_hold(32'h8000_0000, 32'hFFFF_FFFF);
        cmp("neg.sat", r1, 32'h8000_0000);
        cmp("neg.wrap", r0, 32'h7FFF_FFFF);
        cmp("neg.flag", 32'(o1), 32'h1);
        consume();

        // back-to-back start in the handshake cycle
        mac_to_hold(32'd1, 32'd1);
        ready  = 1;
        start  = 1;
        acc_op = 32'd100;
        tick();
        ready     = 0;
        start     = 0;
        cmp("b2b.busy", 32'(b0), 32'h1);
        mul_valid = 1;
        mul_res   = 32'hFFFF_FFFF;
        tick();
        mul_valid = 0;
        tick();
        cmp("b2b.result", r0, 32'd99);
        cmp("b2b.ovf", 32'(o0), 32'h0);
        consume();

        // flush in WAIT_MUL, late product ignored
        start  = 1;
        acc_op = 32'd3;
        tick();
        start = 0;
        kill  = 1;
        tick();
        kill = 0;
        cmp("kill.wait_idle", 32'(b0), 32'h0);
        mul_valid = 1;
        mul_res   = 32'd4;
        tick();
        mul_valid = 0;
        repeat (3) begin
            cmp("kill.no_result", 32'(v0), 32'h0);
            tick();
        end

        // flush in HOLD, also beats a start
        mac_to_hold(32'd20, 32'd22);
        kill  = 1;
        start = 1;
        tick();
        kill  = 0;
        start = 0;
        cmp("kill.hold_valid", 32'(v0), 32'h0);
        cmp("kill.hold_busy", 32'(b0), 32'h0);

        // asynchronous reset while in ADD
        start  = 1;
        acc_op = 32'd7;
        tick();
        start     = 0;
        mul_valid = 1;
        mul_res   = 32'd9;
        tick();
        mul_valid = 0;
        #2 rst_n = 0;
        #1;
        cmp("areset.valid", 32'(v0), 32'h0);
        cmp("areset.busy", 32'(b0), 32'h0);
        cmp("areset.result", r0, 32'h0);
        @(negedge clk);
        rst_n = 1;
        tick();
        start  = 1;
        acc_op = 32'd2;
        tick();
        start     = 0;
        mul_valid = 1;
        mul_res   = 32'd3;
        tick();
        mul_valid = 0;
        wait_valid("areset.fresh");
        cmp("areset.fresh_result", r0, 32'd5);
        consume();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 9) < 3);
            acc_op    = rnd_word();
            mul_valid = ($urandom_range(0, 9) < 4);
            mul_res   = rnd_word();
            kill      = ($urandom_range(0, 39) == 0);
            ready     = ($urandom_range(0, 1) == 1);
            tick();
        end
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
